// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared FSM encoding and packing helper for the serial ADC capture engine
package adc_capture_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  function automatic int pad_width(input int out_w, input int num_ch, input int sample_w);
    return out_w - num_ch * sample_w;
  endfunction
endpackage

// File: rtl/adc_drdy_sync.sv
// adc_drdy_sync: 2-FF synchroniser for DRDY plus a one-cycle falling-edge pulse
//   master_clk, global_reset_n : clock, async active-low reset
//   async_in                   : raw DRDY pin
//   fall_pulse                 : high for one cycle per synchronised 1->0 transition
module adc_drdy_sync (
  input  logic master_clk,
  input  logic global_reset_n,
  input  logic async_in,
  output logic fall_pulse
);
  // sr[1:0] synchronise, sr[2] remembers the previous synchronised level.
  // Reset to 0 so a pin already low at reset release cannot fake an edge.
  logic [2:0] sr;
  always_ff @(posedge master_clk or negedge global_reset_n)
    if (!global_reset_n) sr <= '0;
    else sr <= {sr[1:0], async_in};
  assign fall_pulse = sr[2] & ~sr[1];
endmodule

// File: rtl/adc_serial_capture.sv
// adc_serial_capture: multi-channel serial ADC frame capture with valid/ready output
//   master_clk, global_reset_n : clock, async active-low reset
//   enable, clr_overrun        : frame permit level, overrun clear pulse
//   drdy_in, miso_in           : ADC data-ready (falling edge), per-channel serial data
//   sclk_out                   : divided serial clock, idles low
//   sample_data/valid/ready    : packed frame handshake
//   frame_count, overrun, busy : status
module adc_serial_capture
  import adc_capture_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 24,
  parameter int OUT_W    = 128,
  parameter int SCLK_DIV = 1,
  parameter int CNT_W    = 16
) (
  input  logic              master_clk,
  input  logic              global_reset_n,
  input  logic              enable,
  input  logic              clr_overrun,
  input  logic              drdy_in,
  input  logic [NUM_CH-1:0] miso_in,
  output logic              sclk_out,
  output logic [OUT_W-1:0]  sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [CNT_W-1:0]  frame_count,
  output logic              overrun,
  output logic              busy
);
  localparam int PAD_W = pad_width(OUT_W, NUM_CH, SAMPLE_W);
  localparam int DW = $clog2(SCLK_DIV + 1);
  localparam int BW = $clog2(SAMPLE_W + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_END = DW'(SCLK_DIV);
  localparam logic [BW-1:0] BIT_END = BW'(SAMPLE_W);
  if (PAD_W < 0) begin : g_bad_width
    $error("OUT_W must be at least NUM_CH*SAMPLE_W");
  end
  state_t state, state_n;
  logic edge_pulse, start, fall, done, xfer;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [SAMPLE_W-1:0] sh [NUM_CH];
  logic [OUT_W-1:0] packed_word;
  adc_drdy_sync u_sync (
    .master_clk     (master_clk),
    .global_reset_n (global_reset_n),
    .async_in       (drdy_in),
    .fall_pulse     (edge_pulse)
  );
  assign busy = state != IDLE;
  always_ff @(posedge master_clk or negedge global_reset_n)
    if (!global_reset_n) state <= IDLE;
    else state <= state_n;
  // fall: this cycle's edge takes sclk 1->0, the shift instant.
  // done: after the last fall, sclk is held low one full half period plus
  // one cycle before the frame is presented.
  always_comb begin
    state_n = state;
    start = 1'b0;
    fall = 1'b0;
    done = 1'b0;
    xfer = 1'b0;
    case (state)
      IDLE: begin
        start = edge_pulse && enable;
        state_n = start ? SHIFT : IDLE;
      end
      SHIFT: begin
        fall = sclk_out && div_cnt == DIV_LAST;
        done = bit_cnt == BIT_END && div_cnt == DIV_END;
        state_n = done ? HOLD : SHIFT;
      end
      HOLD: begin
        xfer = sample_ready;
        state_n = xfer ? IDLE : HOLD;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge master_clk or negedge global_reset_n)
    if (!global_reset_n) begin
      sclk_out <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sample_data <= '0;
      sample_valid <= 1'b0;
      frame_count <= '0;
      overrun <= 1'b0;
    end else begin
      if (start) begin
        sclk_out <= 1'b1;
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        if (bit_cnt == BIT_END) div_cnt <= div_cnt + DW'(1);
        else if (div_cnt == DIV_LAST) begin
          sclk_out <= ~sclk_out;
          div_cnt <= '0;
          bit_cnt <= bit_cnt + BW'(fall);
        end else div_cnt <= div_cnt + DW'(1);
      end
      if (done) sample_data <= packed_word;
      sample_valid <= done ? 1'b1 : xfer ? 1'b0 : sample_valid;
      if (xfer) frame_count <= frame_count + CNT_W'(1);
      overrun <= (edge_pulse && busy) || (overrun && !clr_overrun);
    end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    always_ff @(posedge master_clk or negedge global_reset_n)
      if (!global_reset_n) sh[k] <= '0;
      else if (start) sh[k] <= '0;
      else if (fall) sh[k] <= (sh[k] << 1) | SAMPLE_W'(miso_in[k]);
    assign packed_word[k*SAMPLE_W +: SAMPLE_W] = sh[k];
  end
  // Tag holds the count of frames already accepted, i.e. before this frame's increment.
  if (PAD_W > 0) begin : g_tag
    assign packed_word[OUT_W-1 -: PAD_W] = PAD_W'(frame_count);
  end
endmodule

// File: tb/tb_adc_serial_capture.sv
// tb_adc_serial_capture: directed table-driven bench for adc_serial_capture
module tb_adc_serial_capture;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, clr = 1'b0, drdy = 1'b1, ready = 1'b1;
  logic [3:0] miso = '0;
  logic [3:0][23:0] cur = '0;
  logic sclk0, valid0, ovr0, busy0;
  logic [127:0] data0;
  logic [15:0] fc0;
  logic sclk1, valid1, ovr1, busy1;
  logic [127:0] data1;
  logic [3:0] fc1;
  logic drdy2 = 1'b1, ready2 = 1'b1;
  logic [3:0] miso2 = '0;
  logic [3:0][15:0] cur2 = '0;
  logic sclk2, valid2, ovr2, busy2;
  logic [63:0] data2;
  logic [15:0] fc2;
  int checks = 0, errors = 0;
  int bp0 = 0, bp2 = 0, pulses0 = 0, exp_fc = 0;
  always #5 clk = ~clk;
  adc_serial_capture dut0 (
    .master_clk(clk), .global_reset_n(rst_n), .enable(enable), .clr_overrun(clr),
    .drdy_in(drdy), .miso_in(miso), .sclk_out(sclk0), .sample_data(data0),
    .sample_valid(valid0), .sample_ready(ready), .frame_count(fc0), .overrun(ovr0), .busy(busy0)
  );
  adc_serial_capture #(.CNT_W(4)) dut1 (
    .master_clk(clk), .global_reset_n(rst_n), .enable(enable), .clr_overrun(clr),
    .drdy_in(drdy), .miso_in(miso), .sclk_out(sclk1), .sample_data(data1),
    .sample_valid(valid1), .sample_ready(ready), .frame_count(fc1), .overrun(ovr1), .busy(busy1)
  );
  adc_serial_capture #(.SAMPLE_W(16), .OUT_W(64), .SCLK_DIV(3)) dut2 (
    .master_clk(clk), .global_reset_n(rst_n), .enable(1'b1), .clr_overrun(1'b0),
    .drdy_in(drdy2), .miso_in(miso2), .sclk_out(sclk2), .sample_data(data2),
    .sample_valid(valid2), .sample_ready(ready2), .frame_count(fc2), .overrun(ovr2), .busy(busy2)
  );
  // ADC model: present the next bit MSB-first shortly after each SCLK rise.
  always @(posedge busy0) bp0 = 0;
  always @(posedge sclk0) begin
    pulses0++;
    #1;
    for (int k = 0; k < 4; k++) miso[k] = (bp0 < 24) ? cur[k][23-bp0] : 1'b0;
    bp0++;
  end
  always @(posedge busy2) bp2 = 0;
  always @(posedge sclk2) begin
    #1;
    for (int k = 0; k < 4; k++) miso2[k] = (bp2 < 16) ? cur2[k][15-bp2] : 1'b0;
    bp2++;
  end
  typedef struct packed {
    logic [3:0][23:0] c;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl [4];
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic start_frame(input logic [3:0][23:0] v);
    int n;
    cur = v;
    pulses0 = 0;
    drdy = 1'b0;
    n = 0;
    while (!busy0 && n < 12) begin
      cyc();
      n++;
    end
    check("busy_rise", busy0, 1);
    drdy = 1'b1;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!valid0 && n < 300) begin
      cyc();
      n++;
    end
  endtask
  initial begin
    int n, rises, bad, run;
    logic prev, seen, stable;
    logic [127:0] hold_data, e;
    tbl[0].c = {24'h000001, 24'hFFFFFF, 24'h123456, 24'hA5A5A5};
    tbl[0].exp = {32'h0, 24'h000001, 24'hFFFFFF, 24'h123456, 24'hA5A5A5};
    tbl[1].c = '0;
    tbl[1].exp = {32'h1, 96'h0};
    tbl[2].c = {24'hC3C3C3, 24'h5A5A5A, 24'h7FFFFE, 24'h800001};
    tbl[2].exp = {32'h2, 24'hC3C3C3, 24'h5A5A5A, 24'h7FFFFE, 24'h800001};
    tbl[3].c = {96{1'b1}};
    tbl[3].exp = {32'h3, {96{1'b1}}};
    repeat (3) cyc();
    check("rst_sclk", sclk0, 0);
    check("rst_valid", valid0, 0);
    check("rst_busy", busy0, 0);
    check("rst_overrun", ovr0, 0);
    check("rst_fc", fc0, 0);
    check("rst_data", data0, 0);
    rst_n = 1'b1;
    repeat (3) cyc();
    // async reset mid-SHIFT
    start_frame(tbl[0].c);
    repeat (10) cyc();
    #3 rst_n = 1'b0;
    #1;
    check("midrst_sclk", sclk0, 0);
    check("midrst_valid", valid0, 0);
    check("midrst_busy", busy0, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      cyc();
      seen = seen | valid0 | busy0;
    end
    check("post_rst_idle", seen, 0);
    // table-driven frames
    for (int i = 0; i < 4; i++) begin
      start_frame(tbl[i].c);
      wait_valid(n);
      check("latency", n, 49);
      check("frame_data", data0, tbl[i].exp);
      check("sclk_pulses", pulses0, 24);
      cyc();
      exp_fc++;
      check("valid_drop", valid0, 0);
      check("fc_inc", fc0, exp_fc);
      repeat (4) cyc();
    end
    // backpressure, overrun in HOLD, coincident clear loses to set
    ready = 1'b0;
    start_frame(tbl[2].c);
    wait_valid(n);
    hold_data = data0;
    e = {32'(exp_fc), tbl[2].c};
    check("hold_data", data0, e);
    drdy = 1'b0;
    cyc();
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      stable = stable & valid0 & (data0 == hold_data);
    end
    check("hold_stable", stable, 1);
    check("overrun_set_wins", ovr0, 1);
    check("fc_hold", fc0, exp_fc);
    ready = 1'b1;
    cyc();
    exp_fc++;
    check("fc_xfer", fc0, exp_fc);
    drdy = 1'b1;
    repeat (5) cyc();
    check("dropped_edge_idle", busy0, 0);
    check("overrun_sticky", ovr0, 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("overrun_clr", ovr0, 0);
    // enable low ignores DRDY
    enable = 1'b0;
    pulses0 = 0;
    drdy = 1'b0;
    repeat (8) cyc();
    check("dis_busy", busy0, 0);
    check("dis_pulses", pulses0, 0);
    check("dis_overrun", ovr0, 0);
    drdy = 1'b1;
    repeat (4) cyc();
    // enable dropped mid-frame
    enable = 1'b1;
    start_frame(tbl[0].c);
    n = 0;
    while (pulses0 < 10 && n < 100) begin
      cyc();
      n++;
    end
    enable = 1'b0;
    wait_valid(n);
    e = {32'(exp_fc), tbl[0].c};
    check("en_drop_data", data0, e);
    check("en_drop_pulses", pulses0, 24);
    cyc();
    enable = 1'b1;
    // frame counter wrap on a 4-bit counter
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 17; i++) begin
      start_frame(tbl[i%4].c);
      wait_valid(n);
      check("tag_wrap", data1[127:96], i % 16);
      cyc();
      repeat (3) cyc();
    end
    check("fc1_wrap", fc1, 1);
    check("fc0_17", fc0, 17);
    // SCLK_DIV=3, SAMPLE_W=16, OUT_W=64: no tag
    cur2 = {16'hBEEF, 16'h0001, 16'h8000, 16'h1234};
    drdy2 = 1'b0;
    n = 0;
    while (!busy2 && n < 12) begin
      cyc();
      n++;
    end
    check("d2_busy", busy2, 1);
    drdy2 = 1'b1;
    prev = 1'b0;
    run = 0;
    rises = 0;
    bad = 0;
    n = 0;
    while (!valid2 && n < 300) begin
      if (sclk2 != prev) begin
        if (run > 0 && run != 3) bad++;
        if (sclk2) rises++;
        run = 1;
        prev = sclk2;
      end else run++;
      cyc();
      n++;
    end
    check("d2_latency", n, 97);
    check("d2_pulses", rises, 16);
    check("d2_halfperiod", bad, 0);
    check("d2_data", data2, 64'hBEEF_0001_8000_1234);
    cyc();
    check("d2_fc", fc2, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
